// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, types and lookahead helper for the pipelined CLA adder
//
// Contents:
//   DEF_WIDTH / DEF_GROUP : default operand width and lookahead group size
//   LA_MAX                : widest vector the lookahead helper handles
//   gp_t                  : group generate/propagate pair
//   cla_ng()              : number of first-level groups for a width/group pair
//   cla_lookahead()       : flat sum-of-products carry into position n

package cla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;
  localparam int LA_MAX    = 64;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int cla_ng(input int width, input int group);
    return width / group;
  endfunction

  // Carry into position n, written as the full lookahead expansion
  // ci&p[0..n-1] | g[0]&p[1..n-1] | ... | g[n-1]; terms are OR-combined.
  function automatic logic cla_lookahead(input logic [LA_MAX-1:0] p,
                                         input logic [LA_MAX-1:0] g,
                                         input logic              ci,
                                         input int                n);
    logic acc;
    logic term;
    acc = ci;
    for (int k = 0; k < n; k++) acc = acc & p[k];
    for (int j = 0; j < n; j++) begin
      term = g[j];
      for (int k = j + 1; k < n; k++) term = term & p[k];
      acc = acc | term;
    end
    return acc;
  endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational first-level lookahead group
//
// Ports:
//   p, g  in  GROUP  bitwise propagate / generate for this group
//   cin   in  1      carry into bit 0 of the group
//   c     out GROUP  carry into each bit of the group (c[0] == cin)
//   gp    out gp_t   group generate / propagate (independent of cin)

module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic [GROUP-1:0] c,
  output gp_t              gp
);

  always_comb begin
    c = '0;
    for (int i = 0; i < GROUP; i++) begin
      c[i] = cla_lookahead(LA_MAX'(p), LA_MAX'(g), cin, i);
    end
    gp.g = cla_lookahead(LA_MAX'(p), LA_MAX'(g), 1'b0, GROUP);
    gp.p = &p;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage pipelined two-level carry-lookahead adder with valid/ready
//
// Optional feature macro: CLA_SUB_EN (adds the sub port; sub=1 computes a - b).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready is combinational from out_ready)
//   a, b, cin            operands and carry-in
//   sub                  subtract mode (CLA_SUB_EN only)
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       result, carry out of the msb, signed overflow

module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = cla_ng(WIDTH, GROUP);

  generate
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP || NG > LA_MAX) begin : g_bad_cfg
      $fatal(1, "cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP");
    end
  endgenerate

  // ---------------- operand conditioning ----------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CLA_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // ---------------- pipeline control ----------------
  logic s1_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;

  // ---------------- stage 1: bitwise and group G/P ----------------
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  gp_t  [NG-1:0]    gp_in;
  logic [WIDTH-1:0] s1_c_unused;

  assign p_in = a ^ b_eff;
  assign g_in = a & b_eff;

  for (genvar j = 0; j < NG; j++) begin : g_s1_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .p   (p_in[j*GROUP +: GROUP]),
      .g   (g_in[j*GROUP +: GROUP]),
      .cin (1'b0),
      .c   (s1_c_unused[j*GROUP +: GROUP]),
      .gp  (gp_in[j])
    );
  end

  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  gp_t  [NG-1:0]    s1_gp;
  logic             s1_cin;
  logic             s1_a_msb;
  logic             s1_b_msb;

  // Data registers carry no reset; s1_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_p     <= p_in;
      s1_g     <= g_in;
      s1_gp    <= gp_in;
      s1_cin   <= cin_eff;
      s1_a_msb <= a[WIDTH-1];
      s1_b_msb <= b_eff[WIDTH-1];
    end
  end

  // ---------------- stage 2: group carries, in-group carries, sum ----------------
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] carry;
  gp_t  [NG-1:0]    s2_gp_unused;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    for (int j = 0; j < NG; j++) begin
      grp_g[j] = s1_gp[j].g;
      grp_p[j] = s1_gp[j].p;
    end
    for (int j = 0; j <= NG; j++) begin
      grp_c[j] = cla_lookahead(LA_MAX'(grp_p), LA_MAX'(grp_g), s1_cin, j);
    end
  end

  for (genvar j = 0; j < NG; j++) begin : g_s2_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .p   (s1_p[j*GROUP +: GROUP]),
      .g   (s1_g[j*GROUP +: GROUP]),
      .cin (grp_c[j]),
      .c   (carry[j*GROUP +: GROUP]),
      .gp  (s2_gp_unused[j])
    );
  end

  assign sum_d = s1_p ^ carry;
  assign ovf_d = (s1_a_msb == s1_b_msb) && (sum_d[WIDTH-1] != s1_a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= 1'b1;
        sum       <= sum_d;
        cout      <= grp_c[NG];
        ovf       <= ovf_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed self-checking bench for cla_pipe_adder (32/4 and 16/8)

module tb_cla_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic        sub16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] sum16;
  logic        cout16;
  logic        ovf16;

  int errors = 0;
  int checks = 0;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(8)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
`ifdef CLA_SUB_EN
    .sub       (sub16),
`endif
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .cout      (cout16),
    .ovf       (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives one op into an empty 32-bit pipe with out_ready high and
  // samples out_valid one and two edges later.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                        input logic tcin, input logic tsub,
                        output logic acc, output logic v1, output logic v2,
                        output logic [31:0] s, output logic c, output logic o);
    @(negedge clk);
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1 acc = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    v1 = out_valid;
    @(negedge clk);
    v2 = out_valid; s = sum; c = cout; o = ovf;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; out_ready = 1'b0;
    in_valid16 = 1'b1; a16 = 16'h00ff; b16 = 16'h0001;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL rst_sum: got %h expected 00000000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL rst_cout_ovf: got %b expected 00", {cout, ovf}); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL rst_in_ready16: got %b expected 1", in_ready16); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); end
    checks++; if ({sum, cout, ovf} !== 34'h0) begin errors++; $display("FAIL post_rst_result: got %h expected 0", {sum, cout, ovf}); end
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid16: got %b expected 0", out_valid16); end
  endtask

  task automatic test_full_carry;
    logic acc, v1, v2, c, o;
    logic [31:0] s;
    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, acc, v1, v2, s, c, o);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL carry_accept: got %b expected 1", acc); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL carry_early_valid: got %b expected 0", v1); end
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL carry_valid: got %b expected 1", v2); end
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL carry_sum: got %h expected 00000000", s); end
    checks++; if ({c, o} !== 2'b10) begin errors++; $display("FAIL carry_cout_ovf: got %b expected 10", {c, o}); end
  endtask

  task automatic test_overflow;
    logic acc, v1, v2, c, o;
    logic [31:0] s;
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, acc, v1, v2, s, c, o);
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", v2); end
    checks++; if (s !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum: got %h expected 80000000", s); end
    checks++; if ({c, o} !== 2'b01) begin errors++; $display("FAIL ovf_cout_ovf: got %b expected 01", {c, o}); end
  endtask

  task automatic test_backpressure;
    logic [31:0] op_a [10];
    logic [31:0] op_b [10];
    logic        op_c [10];
    logic [33:0] q [$];
    logic [33:0] exp;
    logic [32:0] full;
    logic        prev_stall;
    logic [31:0] prev_sum;
    int sent, got;
    for (int i = 0; i < 10; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      op_c[i] = 1'($urandom_range(0, 1));
    end
    op_a[0] = 32'h8000_0000; op_b[0] = 32'h8000_0000; op_c[0] = 1'b0;
    sent = 0; got = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = ((cyc % 2) == 0);
      if (sent < 10) begin
        in_valid = 1'b1; a = op_a[sent]; b = op_b[sent]; cin = op_c[sent]; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== prev_sum) begin
          errors++; $display("FAIL bp_hold: got valid=%b sum=%h expected valid=1 sum=%h", out_valid, sum, prev_sum);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got sum=%h expected no result", sum);
        end else begin
          exp = q.pop_front();
          if ({ovf, cout, sum} !== exp) begin
            errors++; $display("FAIL bp_result %0d: got %h expected %h", got, {ovf, cout, sum}, exp);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum = sum;
      if (in_valid && in_ready) begin
        full = {1'b0, a} + {1'b0, b} + {32'h0, cin};
        exp  = {(a[31] == b[31]) && (full[31] != a[31]), full[32], full[31:0]};
        q.push_back(exp);
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", got); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d expected 0", q.size()); end
  endtask

`ifdef CLA_SUB_EN
  task automatic test_sub;
    logic acc, v1, v2, c, o;
    logic [31:0] s;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, acc, v1, v2, s, c, o);
    checks++; if (s !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_5_7_sum: got %h expected fffffffe", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_5_7_cout: got %b expected 0", c); end
    run_op(32'd7, 32'd5, 1'b0, 1'b1, acc, v1, v2, s, c, o);
    checks++; if (s !== 32'd2) begin errors++; $display("FAIL sub_7_5_sum: got %h expected 00000002", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_7_5_cout: got %b expected 1", c); end
    sub = 1'b0;
  endtask
`endif

  task automatic test_reset_midflight;
    logic acc, v1, v2, c, o;
    logic [31:0] s;
    @(negedge clk);
    out_ready = 1'b0; out_ready16 = 1'b0; cin = 1'b0; cin16 = 1'b0;
    in_valid = 1'b1; a = 32'd1; b = 32'd1;
    in_valid16 = 1'b1; a16 = 16'd1; b16 = 16'd1;
    @(negedge clk);
    a = 32'd2; b = 32'd2; a16 = 16'd2; b16 = 16'd2;
    @(negedge clk);
    in_valid = 1'b0; in_valid16 = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid: got %b expected 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (in_ready16 !== 1'b0) begin errors++; $display("FAIL full_in_ready16: got %b expected 0", in_ready16); end
    rst = 1'b1; out_ready = 1'b1; out_ready16 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL midrst_valid16: got %b expected 0", out_valid16); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drain: got %b expected 0", out_valid); end
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL midrst_drain16: got %b expected 0", out_valid16); end
    run_op(32'd3, 32'd4, 1'b0, 1'b0, acc, v1, v2, s, c, o);
    checks++; if ({v1, v2} !== 2'b01) begin errors++; $display("FAIL midrst_latency: got %b expected 01", {v1, v2}); end
    checks++; if (s !== 32'd7) begin errors++; $display("FAIL midrst_sum: got %h expected 00000007", s); end
    @(negedge clk);
    in_valid16 = 1'b1; a16 = 16'd3; b16 = 16'd4; cin16 = 1'b0;
    @(negedge clk);
    in_valid16 = 1'b0;
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL midrst16_early: got %b expected 0", out_valid16); end
    @(negedge clk);
    checks++; if (out_valid16 !== 1'b1) begin errors++; $display("FAIL midrst16_valid: got %b expected 1", out_valid16); end
    checks++; if ({sum16, cout16, ovf16} !== {16'd7, 2'b00}) begin errors++; $display("FAIL midrst16_result: got %h expected %h", {sum16, cout16, ovf16}, {16'd7, 2'b00}); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
    test_reset;
    test_full_carry;
    test_overflow;
    test_backpressure;
`ifdef CLA_SUB_EN
    test_sub;
`endif
    test_reset_midflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, two-stage pipelined carry-lookahead adder with a valid/ready handshake. It generalises the fixed 4-bit lookahead unit to any width built from GROUP-bit lookahead groups, with a second lookahead level across groups. It sits in the 32-bit datapath (ALU add path) and supplies sum, carry-out and signed overflow two cycles after acceptance, with full backpressure.

## Interface
- WIDTH, 32: operand/sum width; must be a multiple of GROUP, ≥ GROUP
- GROUP, 4: bits per first-level lookahead group; 2..8
- clk  in  1  rising-edge clock; one clock domain, no other clock
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract mode; present only with CLA_SUB_EN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: a[msb]==b_eff[msb] && sum[msb]!=a[msb]

## Operation
- Transfer occurs on a rising clk edge where valid && ready; the same rule applies on both ports.
- Stage 1 (S1), on accept:
  - bitwise g = a & b_eff and p = a ^ b_eff
  - per-group G/P: G = g[k-1] | p[k-1]&g[k-2] | …, P = &p
  - registers p, g, group G/P, cin_eff and the a/b_eff MSBs.
- Stage 2 (S2), on S1 advancing:
  - second-level lookahead across the NG = WIDTH/GROUP groups gives group carry-ins: C[j+1] = G[j] | P[j]&C[j], C[0] = cin_eff, expanded as a flat lookahead and not rippled
  - in-group carries come from the same lookahead form
  - sum = p ^ carry; cout = C[NG]
  - registers sum, cout and ovf.
- Carry terms are OR-combined. XOR is not used for carry combination.
- Pipeline control:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - s1_load = in_valid && in_ready
  - in_ready = !s1_valid || !out_valid || out_ready (combinational from out_ready)
- Outputs hold stable while out_valid && !out_ready. No result is dropped or duplicated.
- Simultaneous load and drain of the same stage in one cycle is legal and sustains one result per cycle.
- Reset values (rst high at an edge):
  - s1_valid = 0, out_valid = 0
  - sum = 0, cout = 0, ovf = 0
  - in_ready reads 1 from the cycle after reset
- Reset mid-operation discards both in-flight results. No output handshake completes on the reset edge.
- While rst is high, in_valid is ignored.

## Timing
- Latency: accept at edge N gives out_valid at edge N+2 when there is no stall.
- Throughput: 1 op/cycle with out_ready held high.
- Stall behaviour:
  - one stall cycle with both stages full deasserts in_ready
  - the S1 contents advance on the first edge with out_ready high
- in_ready has a combinational path from out_ready. Consumers must not drive out_ready from in_ready.
- Critical path: S2 two-level lookahead plus sum XOR. At WIDTH = 32, GROUP = 4 it spans 8 groups.

## Configuration
- CLA_SUB_EN defined:
  - `sub` port exists
  - sub = 1 gives b_eff = ~b and cin_eff = 1; cin is ignored; the result is a − b
  - cout = 1 means no borrow
  - `sub` is sampled with the operands and is registered in S1 only as part of b_eff/cin_eff
- CLA_SUB_EN undefined:
  - no `sub` port
  - b_eff = b, cin_eff = cin

## Structure
- Package cla_pkg holds:
  - default WIDTH/GROUP constants
  - NG = WIDTH/GROUP helper function
  - a gp_t typedef {g, p} for group generate/propagate
- Elaboration check: WIDTH % GROUP == 0, otherwise a fatal error.
- One sub-module, cla_group, parametrised by GROUP:
  - inputs: p, g (GROUP bits), cin
  - outputs: in-group carries, group G, group P
  - fully combinational
  - instantiated NG times in S1 (G/P) and reused in S2 (carries)

## Test plan
- Reset with in_valid high: during reset and one cycle after, out_valid = 0, sum = 0, cout = 0, ovf = 0. in_ready = 1 the cycle after reset.
- Full-width carry: a = 0xFFFFFFFF, b = 0, cin = 1 → sum = 0x00000000, cout = 1, ovf = 0, valid exactly 2 cycles after accept.
- Signed overflow: a = 0x7FFFFFFF, b = 1, cin = 0 → sum = 0x80000000, cout = 0, ovf = 1.
- Backpressure: stream 10 random ops with out_ready toggling 1010… → results match a scoreboard in order; none lost or duplicated; sum stable while stalled.
- CLA_SUB_EN only: sub = 1, a = 5, b = 7 → sum = 0xFFFFFFFE, cout = 0. Then a = 7, b = 5 → sum = 2, cout = 1.
- Reset asserted with both stages full → no out_valid after reset. The next accepted op (3 + 4) returns 7 two cycles later. Repeat with WIDTH = 16, GROUP = 8.
